shift_unit: RTL and testbench
=============================

# shift_unit

Two-stage pipelined shift/rotate execute unit for the 16-bit CPU datapath. Sits between operand fetch and writeback. Accepts an operand, a 5-bit amount and an opcode over a valid/ready handshake. Produces rotate, logical-shift and arithmetic-shift results by rotating the operand and applying a fill mask. Optional zero/carry flags go to the status register.

## Interface
- WIDTH, 16, datapath width; only 16 is supported
- AMT_W, 5, shift-amount width (0..31)

- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/op presented
- in_ready  output  1  unit can accept this cycle
- in_op  input  3  000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, others illegal
- in_data  input  WIDTH  operand
- in_amt  input  AMT_W  shift amount
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  result
- out_err  output  1  illegal opcode flag, qualified by out_valid
- out_zero  output  1  result == 0 (SHIFT_UNIT_FLAGS_EN only)
- out_carry  output  1  last bit shifted out (SHIFT_UNIT_FLAGS_EN only)

## Operation
- Stage 1 (S1) registers op, data and amt on an in_valid && in_ready transfer.
- Stage 2 (S2) computes the result from the S1 registers and registers it with its flags.
- Rotate amount is amt[3:0] for every op.
- ROL/ROR: result = operand rotated by amt mod 16.
- SLL, n = amt:
  - n = 0: operand passes through.
  - 1..15: operand rotated left by n, low n bits cleared.
  - n >= 16: result 0.
- SRL: mirror of SLL; the high n bits are cleared; n >= 16 gives 0.
- SRA: as SRL, but the high n bits are filled with operand[15]; n >= 16 gives all operand[15].
- Fill mask is generated from (n, direction) with saturation at 16.
- Carry:
  - amt = 0: carry 0.
  - ROL: result[0]. ROR: result[15].
  - SLL, n in 1..16: operand[16-n]. SRL/SRA, n in 1..16: operand[n-1].
  - SLL/SRL, n > 16: 0. SRA, n > 16: operand[15].
- Zero: result == 16'h0000.
- Illegal op: result = operand unchanged, out_err = 1, zero/carry = 0.

## Timing
- Latency: 2 cycles from input transfer to out_valid, with no backpressure.
- Throughput: 1 operation per cycle.
- Stage advance rules:
  - S2 advances when !out_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = S1 advances (combinational from out_ready, no other input).
- out_data/out_err/flags are held stable while out_valid && !out_ready.
- Input transfer and output transfer in the same cycle with a full pipe: both occur, nothing is lost or duplicated.
- Results are delivered strictly in input order.
- Reset, asynchronous, at any point including mid-operation:
  - s1_valid = 0 and out_valid = 0; all in-flight ops are discarded.
  - out_data = 0, out_err = 0, out_zero = 0, out_carry = 0.
  - in_ready = 1 from the first cycle after rst deasserts.

## Configuration
- SHIFT_UNIT_FLAGS_EN defined: out_zero and out_carry ports exist and carry the registered flags as above.
- SHIFT_UNIT_FLAGS_EN undefined: both ports and their logic are absent. Data, err and handshake timing are identical.

## Structure
- Shared package cpu_shift_pkg:
  - op encoding constants (OP_ROL..OP_SRA)
  - WIDTH = 16 constant
  - helper typedef for the {op, data, amt} S1 bundle
- Sub-module shift_mask_gen: combinational; (amt, dir_left) -> 16-bit fill mask, saturating at n >= 16.
- Rotation is done inline in S2 by the existing CPU rotate logic.

## Test plan
- ROL 0x8001 amt 1 -> out_data 0x0003, carry 1, zero 0, out_valid exactly 2 cycles after the transfer.
- SRA 0x8000 amt 4 -> 0xF800, carry 0. SRA 0x8000 amt 20 -> 0xFFFF, carry 1.
- SLL 0x00FF amt 20 -> 0x0000, zero 1, carry 0. SRL 0x0003 amt 1 -> 0x0001, carry 1. ROR 0x1234 amt 16 -> 0x1234, carry 0.
- Backpressure:
  - Stimulus: 3 back-to-back ops, out_ready held 0 for 4 cycles.
  - Required: in_ready drops once S1 and S2 are full; out_data stays stable while stalled; all 3 results emerge in order after out_ready rises; no loss or duplicate.
- Illegal op 3'b101, data 0xA5A5 -> out_data 0xA5A5, out_err 1.
- Reset mid-stream:
  - Stimulus: rst asserted while 2 ops are in flight.
  - Required: out_valid = 0 immediately; no stale result appears after deassert; the next op returns correctly with 2-cycle latency.

Source files
------------

// File: rtl/cpu_shift_pkg.sv
// Shared definitions for the shift/rotate execute unit: opcodes, widths, S1 bundle.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_shift_pkg;

   localparam int WIDTH = 16;
   localparam int AMT_W = 5;

   localparam logic [2:0] OP_ROL = 3'b000;
   localparam logic [2:0] OP_ROR = 3'b001;
   localparam logic [2:0] OP_SLL = 3'b010;
   localparam logic [2:0] OP_SRL = 3'b011;
   localparam logic [2:0] OP_SRA = 3'b100;

   // Operation captured by stage 1 on an input transfer
   typedef struct packed {
      logic [2:0]       op;
      logic [WIDTH-1:0] data;
      logic [AMT_W-1:0] amt;
   } s1_t;

endpackage

// File: rtl/shift_mask_gen.sv
// Fill-mask generator: marks the bit positions a shift of n vacates (low bits for left, high for right).
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: amt (shift count 0..31), dir_left (1 = left shift), mask (1 = vacated position).
module shift_mask_gen
   import cpu_shift_pkg::*;
(
   input  logic [AMT_W-1:0] amt,
   input  logic             dir_left,
   output logic [WIDTH-1:0] mask
);

   logic sat;

   // Any count of 16 or more vacates every position
   assign sat = (amt >= AMT_W'(WIDTH));

   always_comb begin
      mask = '0;
      if (sat) begin
         mask = '1;
      end else if (dir_left) begin
         mask = ~({WIDTH{1'b1}} << amt[3:0]);
      end else begin
         mask = ~({WIDTH{1'b1}} >> amt[3:0]);
      end
   end

endmodule

// File: rtl/shift_unit.sv
// Two-stage shift/rotate execute unit: rotate the operand, then apply a fill mask for shifts.
// Latency: 2 cycles from input transfer to out_valid; throughput 1 op/cycle.
// Backpressure: out_ready low stalls S2, then S1; in_ready drops once both stages are full.
// Ports: clk/rst (async active-high), in_valid/in_ready/in_op/in_data/in_amt (request),
//        out_valid/out_ready/out_data/out_err (result), out_zero/out_carry (flags).
// Optional: SHIFT_UNIT_FLAGS_EN adds the out_zero/out_carry ports and their logic.
module shift_unit
   import cpu_shift_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err
`ifdef SHIFT_UNIT_FLAGS_EN
   ,
   output logic             out_zero,
   output logic             out_carry
`endif
);

   logic             s1_valid;
   s1_t              s1_q;
   logic             s2_adv;
   logic             s1_adv;

   logic [3:0]       rot_amt;
   logic [WIDTH-1:0] rol_res;
   logic [WIDTH-1:0] ror_res;
   logic             mask_left;
   logic [WIDTH-1:0] fill_mask;
   logic [WIDTH-1:0] res;
   logic             err;

   // Handshake: in_ready depends only on pipeline state and out_ready
   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   // Rotation always uses amt mod 16; shifts reuse it and mask off vacated bits
   assign rot_amt = s1_q.amt[3:0];
   assign rol_res = (s1_q.data << rot_amt) | (s1_q.data >> (5'd16 - {1'b0, rot_amt}));
   assign ror_res = (s1_q.data >> rot_amt) | (s1_q.data << (5'd16 - {1'b0, rot_amt}));

   assign mask_left = (s1_q.op == OP_SLL);

   shift_mask_gen u_mask (
      .amt      (s1_q.amt),
      .dir_left (mask_left),
      .mask     (fill_mask)
   );

   always_comb begin
      res = s1_q.data;
      err = 1'b0;
      case (s1_q.op)
         OP_ROL:  res = rol_res;
         OP_ROR:  res = ror_res;
         OP_SLL:  res = rol_res & ~fill_mask;
         OP_SRL:  res = ror_res & ~fill_mask;
         OP_SRA:  res = (ror_res & ~fill_mask) | (fill_mask & {WIDTH{s1_q.data[WIDTH-1]}});
         default: err = 1'b1;
      endcase
   end

`ifdef SHIFT_UNIT_FLAGS_EN
   logic       carry;
   logic       zero;
   logic       amt_over;
   logic [3:0] sll_idx;
   logic [3:0] srl_idx;

   // For n in 1..16 the last bit out is data[16-n] (left) or data[n-1] (right);
   // 4-bit wraparound makes n = 16 land on bit 0 / bit 15 respectively.
   assign sll_idx  = 4'd0 - s1_q.amt[3:0];
   assign srl_idx  = s1_q.amt[3:0] - 4'd1;
   assign amt_over = (s1_q.amt > AMT_W'(WIDTH));

   always_comb begin
      carry = 1'b0;
      if (s1_q.amt != '0) begin
         case (s1_q.op)
            OP_ROL:  carry = res[0];
            OP_ROR:  carry = res[WIDTH-1];
            OP_SLL:  carry = amt_over ? 1'b0 : s1_q.data[sll_idx];
            OP_SRL:  carry = amt_over ? 1'b0 : s1_q.data[srl_idx];
            OP_SRA:  carry = amt_over ? s1_q.data[WIDTH-1] : s1_q.data[srl_idx];
            default: carry = 1'b0;
         endcase
      end
   end

   // Illegal ops report no flags even when the passed-through operand is zero
   assign zero = !err && (res == '0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_q      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
`ifdef SHIFT_UNIT_FLAGS_EN
         out_zero  <= 1'b0;
         out_carry <= 1'b0;
`endif
      end else begin
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_data  <= res;
               out_err   <= err;
`ifdef SHIFT_UNIT_FLAGS_EN
               out_zero  <= zero;
               out_carry <= carry;
`endif
            end
         end
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_q.op   <= in_op;
               s1_q.data <= in_data;
               s1_q.amt  <= in_amt;
            end
         end
      end
   end

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: single ops with latency checks, backpressure, illegal op, mid-stream reset.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low.
module tb_shift_unit;
   import cpu_shift_pkg::*;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_data;
   logic [AMT_W-1:0] in_amt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_err;
`ifdef SHIFT_UNIT_FLAGS_EN
   logic             out_zero;
   logic             out_carry;
`endif

   int nvec = 0;
   int nerr = 0;

   shift_unit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
`ifdef SHIFT_UNIT_FLAGS_EN
      ,
      .out_zero  (out_zero),
      .out_carry (out_carry)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One op into an idle pipe; result must appear exactly two edges after the transfer edge
   task automatic run_one(input string tag, input logic [2:0] op, input logic [15:0] d,
                          input logic [4:0] a, input logic [15:0] ed, input logic ee,
                          input logic ez, input logic ec);
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = op;
      in_data  = d;
      in_amt   = a;
      #1;
      chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, 32'(out_data), 32'(ed));
      chk({tag, "_err"}, 32'(out_err), 32'(ee));
`ifdef SHIFT_UNIT_FLAGS_EN
      chk({tag, "_zero"}, 32'(out_zero), 32'(ez));
      chk({tag, "_carry"}, 32'(out_carry), 32'(ec));
`endif
   endtask

   logic [2:0]  bp_op  [3];
   logic [15:0] bp_dat [3];
   logic [4:0]  bp_amt [3];
   logic [15:0] bp_exp [3];

   initial begin
      int idx;
      int got;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_op     = 3'b000;
      in_data   = '0;
      in_amt    = '0;
      out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_vld", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_err", 32'(out_err), 32'd0);
`ifdef SHIFT_UNIT_FLAGS_EN
      chk("rst_zero", 32'(out_zero), 32'd0);
      chk("rst_carry", 32'(out_carry), 32'd0);
`endif
      rst = 1'b0;
      #1;
      chk("rst_inrdy", 32'(in_ready), 32'd1);

      // tag, op, data, amt, exp data, err, zero, carry
      run_one("rol1",    OP_ROL, 16'h8001,  5'd1, 16'h0003, 1'b0, 1'b0, 1'b1);
      run_one("sra4",    OP_SRA, 16'h8000,  5'd4, 16'hF800, 1'b0, 1'b0, 1'b0);
      run_one("sra20",   OP_SRA, 16'h8000, 5'd20, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      run_one("sll20",   OP_SLL, 16'h00FF, 5'd20, 16'h0000, 1'b0, 1'b1, 1'b0);
      run_one("srl1",    OP_SRL, 16'h0003,  5'd1, 16'h0001, 1'b0, 1'b0, 1'b1);
      run_one("ror16",   OP_ROR, 16'h1234, 5'd16, 16'h1234, 1'b0, 1'b0, 1'b0);
      run_one("sll16",   OP_SLL, 16'h8001, 5'd16, 16'h0000, 1'b0, 1'b1, 1'b1);
      run_one("srl0",    OP_SRL, 16'h1234,  5'd0, 16'h1234, 1'b0, 1'b0, 1'b0);
      run_one("sll4",    OP_SLL, 16'h00FF,  5'd4, 16'h0FF0, 1'b0, 1'b0, 1'b0);
      run_one("sra16",   OP_SRA, 16'h7F00, 5'd16, 16'h0000, 1'b0, 1'b1, 1'b0);
      run_one("ror1",    OP_ROR, 16'h0001,  5'd1, 16'h8000, 1'b0, 1'b0, 1'b1);
      run_one("srl8",    OP_SRL, 16'hABCD,  5'd8, 16'h00AB, 1'b0, 1'b0, 1'b1);
      run_one("illegal", 3'b101, 16'hA5A5,  5'd3, 16'hA5A5, 1'b1, 1'b0, 1'b0);

      // Backpressure: three back-to-back ops, out_ready low for the first 4 cycles
      bp_op[0] = OP_SLL; bp_dat[0] = 16'h0001; bp_amt[0] = 5'd1; bp_exp[0] = 16'h0002;
      bp_op[1] = OP_ROL; bp_dat[1] = 16'h1234; bp_amt[1] = 5'd4; bp_exp[1] = 16'h2341;
      bp_op[2] = OP_SRL; bp_dat[2] = 16'hF000; bp_amt[2] = 5'd8; bp_exp[2] = 16'h00F0;
      idx = 0;
      got = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 4);
         in_valid  = (idx < 3);
         if (idx < 3) begin
            in_op   = bp_op[idx];
            in_data = bp_dat[idx];
            in_amt  = bp_amt[idx];
         end
         #1;
         if (cyc == 2) chk("bp_inrdy_low", 32'(in_ready), 32'd0);
         if (cyc == 2 || cyc == 3) chk("bp_hold", 32'(out_data), 32'(bp_exp[0]));
         if (out_valid && out_ready) begin
            if (got < 3) chk("bp_order", 32'(out_data), 32'(bp_exp[got]));
            else chk("bp_extra", 32'(got), 32'd3);
            got++;
         end
         if (in_valid && in_ready) idx++;
         if (got == 3 && idx == 3) break;
      end
      in_valid = 1'b0;
      chk("bp_count", 32'(got), 32'd3);
      @(negedge clk);
      chk("bp_nodup", 32'(out_valid), 32'd0);

      // Reset while two ops are in flight
      @(negedge clk);
      in_valid = 1'b1; in_op = OP_ROL; in_data = 16'h0F00; in_amt = 5'd4;
      @(negedge clk);
      in_op = OP_SRL; in_data = 16'hFF00; in_amt = 5'd8;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mr_pre_vld", 32'(out_valid), 32'd1);
      chk("mr_pre_data", 32'(out_data), 32'hF000);
      rst = 1'b1;
      #1;
      chk("mr_vld", 32'(out_valid), 32'd0);
      chk("mr_data", 32'(out_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mr_inrdy", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mr_nostale", 32'(out_valid), 32'd0);
      end
      run_one("post_rst", OP_SRA, 16'h8421, 5'd2, 16'hE108, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
